// File: rtl/axis_route_scheduler_pkg.sv
// Shared types for the AXI-stream crossbar route scheduler.
// Slot state encoding and index-width helper.
package axis_route_scheduler_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    SWITCH = 2'd2
  } slot_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_route_slot.sv
// One crossbar output route slot.
// Holds current/pending bitmaps, switches at old-source SOF or on timeout.
module axis_route_slot
  import axis_route_scheduler_pkg::*;
#(
  parameter int C_S_STREAM_NUM = 8,
  parameter int C_TIMEOUT_W    = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [C_S_STREAM_NUM-1:0] s_tvalid,
  input  logic [C_S_STREAM_NUM-1:0] s_tuser,
  input  logic                      cfg_wr,
  input  logic [C_S_STREAM_NUM-1:0] cfg_bmp,
  input  logic                      cfg_force,
  output logic [C_S_STREAM_NUM-1:0] src_bmp,
  output logic                      busy,
  output logic                      sw_done,
  output logic                      sw_timeout
);

  localparam int S = C_S_STREAM_NUM;

  slot_state_e          state;
  slot_state_e          state_nxt;
  logic [S-1:0]         cur_bmp;
  logic [S-1:0]         pend_bmp;
  logic [C_TIMEOUT_W-1:0] timer;
  logic                 via_to;
  logic                 go_to;
  logic                 sof_hit;
  logic                 tmr_full;

  assign sof_hit  = |(s_tvalid & s_tuser & cur_bmp);
  assign tmr_full = &timer;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state decode; go_to flags a timeout-forced switch
  always_comb begin
    state_nxt = state;
    go_to     = 1'b0;
    unique case (state)
      RUN: begin
        if (cfg_wr)
          state_nxt = (cfg_force || cur_bmp == '0) ? SWITCH : PEND;
      end
      PEND: begin
        if ((cfg_wr && cfg_force) || sof_hit) begin
          state_nxt = SWITCH;
        end else if (tmr_full) begin
          state_nxt = SWITCH;
          go_to     = 1'b1;
        end
      end
      SWITCH: state_nxt = cfg_wr ? PEND : RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Route registers, timer and completion pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_bmp    <= '0;
      pend_bmp   <= '0;
      timer      <= '0;
      via_to     <= 1'b0;
      sw_done    <= 1'b0;
      sw_timeout <= 1'b0;
    end else begin
      sw_done    <= (state == SWITCH);
      sw_timeout <= (state == SWITCH) && via_to;
      if (state != SWITCH) via_to <= go_to;
      if (cfg_wr) pend_bmp <= cfg_bmp;
      if (state == SWITCH) cur_bmp <= pend_bmp;
      unique case (state)
        RUN:     if (cfg_wr) timer <= '0;
        PEND:    if (!tmr_full) timer <= timer + 1'b1;
        SWITCH:  if (cfg_wr) timer <= '0;
        default: timer <= '0;
      endcase
    end
  end

  // Route output; old source is masked on its SOF beat
  always_comb begin
    src_bmp = cur_bmp;
    busy    = (state != RUN);
    unique case (state)
      RUN:     src_bmp = cur_bmp;
      PEND:    src_bmp = sof_hit ? '0 : cur_bmp;
      SWITCH:  src_bmp = '0;
      default: src_bmp = '0;
    endcase
  end

endmodule

// File: rtl/axis_route_scheduler.sv
// Route scheduler for the AXI-stream pixel crossbar.
// One slot per output; packs per-slot routes into m_src_bmp.
module axis_route_scheduler
  import axis_route_scheduler_pkg::*;
#(
  parameter int C_S_STREAM_NUM = 8,
  parameter int C_M_STREAM_NUM = 8,
  parameter int C_TIMEOUT_W    = 24,
  localparam int IW = idx_w(C_M_STREAM_NUM)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [C_S_STREAM_NUM-1:0]              s_tvalid,
  input  logic [C_S_STREAM_NUM-1:0]              s_tuser,
  input  logic                                   cfg_wr,
  input  logic [IW-1:0]                          cfg_idx,
  input  logic [C_S_STREAM_NUM-1:0]              cfg_bmp,
  input  logic                                   cfg_force,
  output logic [C_M_STREAM_NUM*C_S_STREAM_NUM-1:0] m_src_bmp,
  output logic [C_M_STREAM_NUM-1:0]              cfg_busy,
  output logic [C_M_STREAM_NUM-1:0]              sw_done,
  output logic [C_M_STREAM_NUM-1:0]              sw_timeout
);

  localparam int S = C_S_STREAM_NUM;

  for (genvar k = 0; k < C_M_STREAM_NUM; k++) begin : g_slot
    logic wr_k;
    assign wr_k = cfg_wr && (cfg_idx == IW'(k));

    axis_route_slot #(
      .C_S_STREAM_NUM (C_S_STREAM_NUM),
      .C_TIMEOUT_W    (C_TIMEOUT_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .s_tvalid   (s_tvalid),
      .s_tuser    (s_tuser),
      .cfg_wr     (wr_k),
      .cfg_bmp    (cfg_bmp),
      .cfg_force  (cfg_force),
      .src_bmp    (m_src_bmp[k*S +: S]),
      .busy       (cfg_busy[k]),
      .sw_done    (sw_done[k]),
      .sw_timeout (sw_timeout[k])
    );
  end

endmodule

// File: tb/tb_axis_route_scheduler.sv
// Testbench for axis_route_scheduler.
// Directed scenarios plus random traffic against a reference model.
module tb_axis_route_scheduler;

  localparam int S   = 8;
  localparam int M   = 8;
  localparam int TW  = 4;
  localparam int MAX = (1 << TW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [S-1:0]   s_tvalid, s_tuser;
  logic           cfg_wr;
  logic [2:0]     cfg_idx;
  logic [S-1:0]   cfg_bmp;
  logic           cfg_force;
  logic [M*S-1:0] m_src_bmp;
  logic [M-1:0]   cfg_busy, sw_done, sw_timeout;

  axis_route_scheduler #(
    .C_S_STREAM_NUM (S),
    .C_M_STREAM_NUM (M),
    .C_TIMEOUT_W    (TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tvalid   (s_tvalid),
    .s_tuser    (s_tuser),
    .cfg_wr     (cfg_wr),
    .cfg_idx    (cfg_idx),
    .cfg_bmp    (cfg_bmp),
    .cfg_force  (cfg_force),
    .m_src_bmp  (m_src_bmp),
    .cfg_busy   (cfg_busy),
    .sw_done    (sw_done),
    .sw_timeout (sw_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference model: a route is either live, waiting for the old
  // source's frame start, or being applied this cycle.
  logic [S-1:0] r_cur[M], r_next[M];
  bit r_wait[M], r_apply[M], r_forced_by_to[M];
  bit r_done[M], r_to[M];
  int r_age[M];

  task automatic model_reset();
    for (int k = 0; k < M; k++) begin
      r_cur[k] = '0; r_next[k] = '0; r_wait[k] = 0; r_apply[k] = 0;
      r_forced_by_to[k] = 0; r_done[k] = 0; r_to[k] = 0; r_age[k] = 0;
    end
  endtask

  logic [M*S-1:0] obs_m;
  logic [M-1:0]   obs_busy, obs_done, obs_to;

  task automatic step(input logic [S-1:0] tv, input logic [S-1:0] tu,
                      input logic wr, input logic [2:0] idx,
                      input logic [S-1:0] bmp, input logic frc);
    logic [M*S-1:0] em;
    logic [M-1:0]   eb, ed, et;
    bit             sof[M];
    @(negedge clk);
    s_tvalid = tv; s_tuser = tu; cfg_wr = wr;
    cfg_idx = idx; cfg_bmp = bmp; cfg_force = frc;
    #1;
    for (int k = 0; k < M; k++) begin
      sof[k] = (tv & tu & r_cur[k]) != '0;
      if (r_apply[k] || (r_wait[k] && sof[k])) em[k*S +: S] = '0;
      else em[k*S +: S] = r_cur[k];
      eb[k] = r_wait[k] || r_apply[k];
      ed[k] = r_done[k];
      et[k] = r_to[k];
    end
    obs_m = m_src_bmp; obs_busy = cfg_busy;
    obs_done = sw_done; obs_to = sw_timeout;
    chk("m_src_bmp", 64'(m_src_bmp), 64'(em));
    chk("cfg_busy", 64'(cfg_busy), 64'(eb));
    chk("sw_done", 64'(sw_done), 64'(ed));
    chk("sw_timeout", 64'(sw_timeout), 64'(et));
    @(posedge clk);
    for (int k = 0; k < M; k++) begin
      bit mine;
      mine = wr && (int'(idx) == k);
      r_done[k] = r_apply[k];
      r_to[k]   = r_apply[k] && r_forced_by_to[k];
      if (r_apply[k]) begin
        r_cur[k] = r_next[k];
        r_apply[k] = 0;
        if (mine) begin
          r_next[k] = bmp; r_age[k] = 0; r_wait[k] = 1;
        end
      end else if (r_wait[k]) begin
        if (mine) r_next[k] = bmp;
        if ((mine && frc) || sof[k]) begin
          r_wait[k] = 0; r_apply[k] = 1; r_forced_by_to[k] = 0;
        end else if (r_age[k] >= MAX) begin
          r_wait[k] = 0; r_apply[k] = 1; r_forced_by_to[k] = 1;
        end else begin
          r_age[k]++;
        end
      end else if (mine) begin
        r_next[k] = bmp; r_age[k] = 0;
        r_forced_by_to[k] = 0;
        if (frc || r_cur[k] == '0) r_apply[k] = 1;
        else r_wait[k] = 1;
      end
    end
  endtask

  task automatic idle();
    step('0, '0, 1'b0, 3'd0, '0, 1'b0);
  endtask

  task automatic wr_slot(input logic [2:0] idx, input logic [S-1:0] bmp,
                         input logic frc);
    step('0, '0, 1'b1, idx, bmp, frc);
  endtask

  initial begin
    int n;
    int pulses;
    reset = 1'b1;
    s_tvalid = '0; s_tuser = '0; cfg_wr = 1'b0;
    cfg_idx = '0; cfg_bmp = '0; cfg_force = 1'b0;
    model_reset();
    #12;
    chk("rst_m", 64'(m_src_bmp), 64'd0);
    chk("rst_busy", 64'(cfg_busy), 64'd0);
    reset = 1'b0;

    // 1: empty slot switches straight away
    wr_slot(3'd0, 8'h01, 1'b0);
    idle();
    chk("t1_switch_busy", 64'(obs_busy[0]), 64'd1);
    idle();
    chk("t1_bmp", 64'(obs_m[7:0]), 64'h01);
    chk("t1_done", 64'(obs_done[0]), 64'd1);

    // 2: wait for SOF of old source 0
    wr_slot(3'd0, 8'h04, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(8'h01, 8'h00, 1'b0, 3'd0, '0, 1'b0);
      chk("t2_hold", 64'(obs_m[7:0]), 64'h01);
      chk("t2_busy", 64'(obs_busy[0]), 64'd1);
    end
    step(8'h01, 8'h01, 1'b0, 3'd0, '0, 1'b0);
    chk("t2_sof_mask", 64'(obs_m[7:0]), 64'h00);
    idle();
    idle();
    chk("t2_new", 64'(obs_m[7:0]), 64'h04);

    // 3: old source idle, timeout forces the switch
    wr_slot(3'd0, 8'h02, 1'b0);
    n = 0;
    do begin
      idle();
      n++;
    end while (!obs_done[0] && n < 40);
    chk("t3_latency", 64'(n), 64'd18);
    chk("t3_timeout", 64'(obs_to[0]), 64'd1);

    // 4: rewrite while pending, only the last one applies
    wr_slot(3'd1, 8'h01, 1'b0);
    idle();
    idle();
    pulses = 0;
    wr_slot(3'd1, 8'h02, 1'b0);
    pulses += int'(obs_done[1]);
    wr_slot(3'd1, 8'h08, 1'b0);
    pulses += int'(obs_done[1]);
    step(8'h01, 8'h01, 1'b0, 3'd0, '0, 1'b0);
    pulses += int'(obs_done[1]);
    for (int i = 0; i < 3; i++) begin
      idle();
      pulses += int'(obs_done[1]);
    end
    chk("t4_pulses", 64'(pulses), 64'd1);
    chk("t4_bmp", 64'(obs_m[15:8]), 64'h08);

    // 5: write during SWITCH re-enters PEND
    pulses = 0;
    wr_slot(3'd2, 8'h01, 1'b0);
    wr_slot(3'd2, 8'h04, 1'b0);
    idle();
    pulses += int'(obs_done[2]);
    chk("t5_busy", 64'(obs_busy[2]), 64'd1);
    step(8'h01, 8'h01, 1'b0, 3'd0, '0, 1'b0);
    pulses += int'(obs_done[2]);
    for (int i = 0; i < 3; i++) begin
      idle();
      pulses += int'(obs_done[2]);
    end
    chk("t5_pulses", 64'(pulses), 64'd2);
    chk("t5_bmp", 64'(obs_m[23:16]), 64'h04);

    // 6: async reset while slot 3 is pending
    wr_slot(3'd3, 8'h01, 1'b0);
    idle();
    wr_slot(3'd3, 8'h02, 1'b0);
    idle();
    chk("t6_pend", 64'(obs_busy[3]), 64'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_m", 64'(m_src_bmp), 64'd0);
    chk("t6_busy", 64'(cfg_busy), 64'd0);
    model_reset();
    #1 reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [S-1:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? '0 : S'($urandom);
      step(S'($urandom),
           S'($urandom & $urandom & $urandom & $urandom),
           ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)),
           rb,
           ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
